// File: rtl/axil_mem_regs.sv
// AXI4-Lite slave: ID/CONTROL/STATUS registers plus NUM_MEM byte-writable memory windows.
// B follows the later AW/W handshake by 1 cycle, R follows AR by 2; VALIDs hold with a stable payload until READY.
module axil_mem_regs #(
  parameter int          MEM_AW   = 8,
  parameter int          NUM_MEM  = 2,
  parameter logic [31:0] ID_VALUE = 32'h4D454D32
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] ctrl_o,
  output logic        ctrl_wr_o,
  input  logic [31:0] status_i
);
  localparam int RSEL_W    = $clog2(NUM_MEM + 1);
  localparam int MEM_WORDS = 1 << MEM_AW;
  localparam int MEM_DEPTH = NUM_MEM * MEM_WORDS;
  localparam int MD_W      = $clog2(MEM_DEPTH);
  localparam logic [RSEL_W-1:0] LAST_RGN = RSEL_W'(NUM_MEM);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  function automatic logic [RSEL_W-1:0] rgn_of(input logic [31:0] a);
    return a[MEM_AW+1+RSEL_W : MEM_AW+2];
  endfunction

  function automatic logic [MEM_AW-1:0] word_of(input logic [31:0] a);
    return a[MEM_AW+1:2];
  endfunction

  function automatic logic is_mem(input logic [31:0] a);
    return (rgn_of(a) != '0) && (rgn_of(a) <= LAST_RGN);
  endfunction

  function automatic logic is_ctrl(input logic [31:0] a);
    return (rgn_of(a) == '0) && (word_of(a) == MEM_AW'(4));
  endfunction

  function automatic logic is_reg(input logic [31:0] a);
    return (rgn_of(a) == '0) &&
           ((word_of(a) == MEM_AW'(0)) || (word_of(a) == MEM_AW'(4)) || (word_of(a) == MEM_AW'(5)));
  endfunction

  // Windows are packed back to back, so window k-1 starts at (k-1)*MEM_WORDS.
  function automatic logic [MD_W-1:0] mem_idx(input logic [31:0] a);
    logic [RSEL_W-1:0]        win;
    logic [RSEL_W+MEM_AW-1:0] flat;
    win  = rgn_of(a) - 1'b1;
    flat = {win, word_of(a)};
    return flat[MD_W-1:0];
  endfunction

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] ctrl_q, ctrl_d, araddr_q, araddr_d, rdata_q, rdata_d;
  logic        ctrl_wr_q, ctrl_wr_d;
  logic        cmt, ar_hs;
  logic [31:0] cmt_addr, cmt_data;
  logic [3:0]  cmt_strb;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mem_rd_q;

  // Upper address bits alias and the byte-offset bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, awaddr_q, araddr_q};

  assign S_AXI_AWREADY = S_AXI_ARESETN && ((w_state_q == W_IDLE) || (w_state_q == W_DATA));
  assign S_AXI_WREADY  = S_AXI_ARESETN && ((w_state_q == W_IDLE) || (w_state_q == W_ADDR));
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN && (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_o        = ctrl_q;
  assign ctrl_wr_o     = ctrl_wr_q;
  assign ar_hs         = S_AXI_ARVALID && (r_state_q == R_IDLE);

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cmt       = 1'b0;
    cmt_addr  = awaddr_q;
    cmt_data  = wdata_q;
    cmt_strb  = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          cmt       = 1'b1;
          cmt_addr  = S_AXI_AWADDR;
          cmt_data  = S_AXI_WDATA;
          cmt_strb  = S_AXI_WSTRB;
          w_state_d = W_RESP;
        end else if (S_AXI_AWVALID) begin
          awaddr_d  = S_AXI_AWADDR;
          w_state_d = W_ADDR;
        end else if (S_AXI_WVALID) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_DATA;
        end
      end
      W_ADDR: if (S_AXI_WVALID) begin
        cmt       = 1'b1;
        cmt_data  = S_AXI_WDATA;
        cmt_strb  = S_AXI_WSTRB;
        w_state_d = W_RESP;
      end
      W_DATA: if (S_AXI_AWVALID) begin
        cmt       = 1'b1;
        cmt_addr  = S_AXI_AWADDR;
        w_state_d = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    ctrl_wr_d = cmt && is_ctrl(cmt_addr);
    if (cmt) bresp_d = (is_mem(cmt_addr) || is_reg(cmt_addr)) ? RESP_OKAY : RESP_SLVERR;
    if (ctrl_wr_d) begin
      for (int b = 0; b < 4; b++) begin
        if (cmt_strb[b]) ctrl_d[8*b +: 8] = cmt_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (S_AXI_ARVALID) begin
        araddr_d  = S_AXI_ARADDR;
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rdata_d   = '0;
        rresp_d   = RESP_SLVERR;
        r_state_d = R_DATA;
        if (is_mem(araddr_q)) begin
          rdata_d = mem_rd_q;
          rresp_d = RESP_OKAY;
        end else if (is_reg(araddr_q)) begin
          rresp_d = RESP_OKAY;
          case (word_of(araddr_q))
            MEM_AW'(0): rdata_d = ID_VALUE;
            MEM_AW'(4): rdata_d = ctrl_q;
            default:    rdata_d = status_i;
          endcase
        end
      end
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      ctrl_wr_q <= 1'b0;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      ctrl_q    <= ctrl_d;
      ctrl_wr_q <= ctrl_wr_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read port samples on the AR handshake edge, so a commit on that same edge is not seen (read-first).
  always_ff @(posedge S_AXI_ACLK) begin
    if (cmt && is_mem(cmt_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (cmt_strb[b]) mem[mem_idx(cmt_addr)][8*b +: 8] <= cmt_data[8*b +: 8];
      end
    end
    if (ar_hs && is_mem(S_AXI_ARADDR)) mem_rd_q <= mem[mem_idx(S_AXI_ARADDR)];
  end
endmodule

// File: tb/tb_axil_mem_regs.sv
// Directed bench for axil_mem_regs with a word-level reference model and a per-cycle compare process.
module tb_axil_mem_regs;
  localparam logic [31:0] ID = 32'h4D454D32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, ctrl_o, status_i;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, ctrl_wr_o;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_ctrl = 32'h0;
  logic        exp_ctrl_wr = 1'b0;
  logic [33:0] exp_r [$];
  logic [1:0]  exp_b [$];

  axil_mem_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Address map for MEM_AW=8, NUM_MEM=2: region = addr[11:10], word = addr[9:2].
  task automatic mdl_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int rg, w;
    rg = int'((a >> 10) & 32'd3);
    w  = int'((a >> 2) & 32'd255);
    d = 32'h0;
    r = 2'b10;
    if (rg == 0) begin
      if (w == 0) begin d = ID; r = 2'b00; end
      else if (w == 4) begin d = mdl_ctrl; r = 2'b00; end
      else if (w == 5) begin d = status_i; r = 2'b00; end
    end else if (rg <= 2) begin
      d = mdl_mem.exists(rg * 256 + w) ? mdl_mem[rg * 256 + w] : 32'h0;
      r = 2'b00;
    end
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int rg, w;
    logic [31:0] old;
    rg = int'((a >> 10) & 32'd3);
    w  = int'((a >> 2) & 32'd255);
    r  = 2'b00;
    if (rg == 0) begin
      if (w == 4) begin
        old = mdl_ctrl;
        for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
        mdl_ctrl    = old;
        exp_ctrl_wr = 1'b1;
      end else if (w != 0 && w != 5) r = 2'b10;
    end else if (rg <= 2) begin
      old = mdl_mem.exists(rg * 256 + w) ? mdl_mem[rg * 256 + w] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      mdl_mem[rg * 256 + w] = old;
    end else r = 2'b10;
  endtask

  // Called at posedge+1; returns at posedge+1 when RREADY is high.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    mdl_read(a, ed, er);
    exp_r.push_back({er, ed});
    araddr = a; arvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) check("ar_timeout", 32'(n), 32'd0);
    @(posedge clk); #1 arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    d = rdata; r = rresp;
    if (rready) begin @(posedge clk); #1; end
  endtask

  // W is presented w_lead cycles before AW; lat counts cycles from the later handshake to BVALID minus one.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output logic [1:0] br, output int lat);
    logic aw_ok, w_ok, hs_aw, hs_w;
    logic [1:0] er;
    int t;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
    aw_ok = 1'b0; w_ok = 1'b0; t = 0;
    while (!(aw_ok && w_ok) && t < 50) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_ok = 1'b1; awvalid = 1'b0; end
      if (hs_w)  begin w_ok  = 1'b1; wvalid  = 1'b0; end
      t++;
      if (t == w_lead && !aw_ok) awvalid = 1'b1;
    end
    if (!(aw_ok && w_ok)) check("aw_w_timeout", 32'(t), 32'd0);
    mdl_write(a, d, s, er);
    exp_b.push_back(er);
    lat = 0;
    @(negedge clk);
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    br = bresp;
    if (bready) begin @(posedge clk); #1; end
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"},  32'(wready),  32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_bvalid"},  32'(bvalid),  32'd0);
    check({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check({tag, "_bresp"},   32'(bresp),   32'd0);
    check({tag, "_rresp"},   32'(rresp),   32'd0);
    check({tag, "_rdata"},   rdata,        32'd0);
    check({tag, "_ctrl_o"},  ctrl_o,       32'd0);
    check({tag, "_ctrl_wr"}, 32'(ctrl_wr_o), 32'd0);
  endtask

  logic        hold_r = 1'b0, hold_b = 1'b0;
  logic [31:0] prev_rd;
  logic [1:0]  prev_rr, prev_br;
  logic [33:0] er_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_r = 1'b0; hold_b = 1'b0; exp_ctrl_wr = 1'b0;
    end else begin
      check("ctrl_o_track", ctrl_o, mdl_ctrl);
      check("ctrl_wr_track", 32'(ctrl_wr_o), 32'(exp_ctrl_wr));
      exp_ctrl_wr = 1'b0;
      if (hold_r) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, prev_rd);
        check("r_hold_resp", 32'(rresp), 32'(prev_rr));
      end
      if (hold_b) begin
        check("b_hold_valid", 32'(bvalid), 32'd1);
        check("b_hold_resp", 32'(bresp), 32'(prev_br));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 32'(rvalid), 32'd0);
        else begin
          er_e = exp_r.pop_front();
          check("r_model_data", rdata, er_e[31:0]);
          check("r_model_resp", 32'(rresp), 32'(er_e[33:32]));
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 32'(bvalid), 32'd0);
        else check("b_model_resp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      hold_r = rvalid && !rready; prev_rd = rdata; prev_rr = rresp;
      hold_b = bvalid && !bready; prev_br = bresp;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, br, br2;
    int lat, lat2;
    rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status_i = 32'hCAFE0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_wready",  32'(wready),  32'd1);
    check("post_rst_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;

    axi_read(32'h000, d, r, lat);
    check("id_data", d, 32'h4D454D32);
    check("id_resp", 32'(r), 32'd0);
    check("rd_latency", 32'(lat), 32'd2);
    axi_read(32'h010, d, r, lat);
    check("ctrl_rst_val", d, 32'h0);
    axi_read(32'h014, d, r, lat);
    check("status_data", d, 32'hCAFE0001);
    axi_read(32'h008, d, r, lat);
    check("reg_hole_data", d, 32'h0);
    check("reg_hole_resp", 32'(r), 32'd2);

    axi_write(32'h804, 32'h12345678, 4'hF, 0, br, lat);
    check("wr_latency", 32'(lat), 32'd0);
    check("wr_resp", 32'(br), 32'd0);
    axi_write(32'h404, 32'hDEADBEEF, 4'hF, 0, br, lat);
    axi_write(32'h404, 32'h000000AA, 4'h1, 0, br, lat);
    axi_read(32'h404, d, r, lat);
    check("strb_merge", d, 32'hDEADBEAA);
    axi_read(32'h804, d, r, lat);
    check("mem1_untouched", d, 32'h12345678);
    axi_read(32'h1404, d, r, lat);
    check("alias_read", d, 32'hDEADBEAA);

    bready = 1'b0;
    axi_write(32'h010, 32'h5, 4'hF, 3, br, lat);
    check("w_first_latency", 32'(lat), 32'd0);
    check("ctrl_after_wr", ctrl_o, 32'h5);
    check("ctrl_wr_pulse", 32'(ctrl_wr_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
      check("ctrl_wr_once", 32'(ctrl_wr_o), 32'd0);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_dropped", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    axi_write(32'h010, 32'hFFFFFFFF, 4'h0, 0, br, lat);
    check("ctrl_strb0", ctrl_o, 32'h5);

    axi_write(32'hC00, 32'h99, 4'hF, 0, br, lat);
    check("unmapped_bresp", 32'(br), 32'd2);
    axi_read(32'hC00, d, r, lat);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", 32'(r), 32'd2);
    check("unmapped_rlat", 32'(lat), 32'd2);
    axi_write(32'h000, 32'h1234, 4'hF, 0, br, lat);
    check("id_wr_bresp", 32'(br), 32'd0);
    axi_read(32'h000, d, r, lat);
    check("id_unchanged", d, 32'h4D454D32);
    axi_read(32'h010, d, r, lat);
    check("ctrl_unchanged", d, 32'h5);

    axi_write(32'h408, 32'h22222222, 4'hF, 0, br, lat);
    fork
      axi_write(32'h408, 32'h11111111, 4'hF, 0, br2, lat2);
      axi_read(32'h408, d2, r, lat);
    join
    check("read_first", d2, 32'h22222222);
    axi_read(32'h408, d, r, lat);
    check("read_after_wr", d, 32'h11111111);

    axi_write(32'h40C, 32'h0BADF00D, 4'hF, 0, br, lat);
    awaddr = 32'h40C; awvalid = 1'b1; araddr = 32'h804; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rvalid", 32'(rvalid), 32'd1);
    #2 rst_n = 1'b0; mdl_ctrl = 32'h0;
    #1 chk_rst("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_b_after_rst", 32'(bvalid), 32'd0);
      check("no_r_after_rst", 32'(rvalid), 32'd0);
    end
    @(posedge clk); #1;
    axi_read(32'h40C, d, r, lat);
    check("dropped_commit", d, 32'h0BADF00D);
    check("ctrl_reset_again", ctrl_o, 32'h0);
    axi_write(32'h40C, 32'h600DF00D, 4'hF, 0, br, lat);
    check("clean_wr_resp", 32'(br), 32'd0);
    axi_read(32'h40C, d, r, lat);
    check("clean_rd", d, 32'h600DF00D);

    repeat (2) @(negedge clk);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
